// File: rtl/link_pkg.sv
// Shared types for the board-to-board link: frame header tag, FSM state enums and message struct.
// Optional 3-byte frames with an XOR checksum are selected by defining LINK_CHECKSUM_EN.
package link_pkg;

    localparam logic [5:0] LINK_HDR_TAG = 6'b101000;

`ifdef LINK_CHECKSUM_EN
    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_CORDS, TX_CHK} tx_state_t;
    typedef enum logic [1:0] {RX_HDR, RX_CORDS, RX_CHK} rx_state_t;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_CORDS} tx_state_t;
    typedef enum logic [0:0] {RX_HDR, RX_CORDS} rx_state_t;
`endif

    typedef struct packed {
        logic       ready;
        logic       hit;
        logic [7:0] cords;
    } link_msg_t;

    function automatic logic [7:0] hdr_byte(input logic ready, input logic hit);
        return {LINK_HDR_TAG, ready, hit};
    endfunction

endpackage

// File: rtl/link_rx.sv
// Frame receiver: hunts for a header byte, collects cords (and checksum when LINK_CHECKSUM_EN
// is defined), drops partial frames after an idle gap, and holds the committed remote message.
module link_rx
    import link_pkg::*;
#(
    parameter int RX_GAP_CYCLES = 10_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       expire,
    output logic       commit,
    output link_msg_t  msg
);

    localparam int GAP_W = $clog2(RX_GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RX_GAP_CYCLES);

    rx_state_t        state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
    logic [1:0]       rh_q, rh_d;
    link_msg_t        msg_q, msg_d, frame;
`ifdef LINK_CHECKSUM_EN
    logic [7:0]       cords_q, cords_d;
`endif

    always_comb begin
        gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
        state_d = state_q;
        rh_d    = rh_q;
        gap_d   = (state_q == RX_HDR) ? '0 : gap_inc;
        commit  = 1'b0;
        frame   = {rh_q, rx_data};
`ifdef LINK_CHECKSUM_EN
        cords_d = cords_q;
`endif
        case (state_q)
            RX_HDR: begin
                if (rx_valid && rx_data[7:2] == LINK_HDR_TAG) begin
                    rh_d    = rx_data[1:0];
                    state_d = RX_CORDS;
                end
            end
            RX_CORDS: begin
                if (rx_valid) begin
`ifdef LINK_CHECKSUM_EN
                    cords_d = rx_data;
                    gap_d   = '0;
                    state_d = RX_CHK;
`else
                    commit  = 1'b1;
                    state_d = RX_HDR;
`endif
                end else if (gap_inc == GAP_MAX) begin
                    state_d = RX_HDR;
                end
            end
`ifdef LINK_CHECKSUM_EN
            RX_CHK: begin
                frame = {rh_q, cords_q};
                if (rx_valid) begin
                    commit  = (rx_data == (hdr_byte(rh_q[1], rh_q[0]) ^ cords_q));
                    state_d = RX_HDR;
                end else if (gap_inc == GAP_MAX) begin
                    state_d = RX_HDR;
                end
            end
`endif
            default: state_d = RX_HDR;
        endcase

        // A commit in the same cycle as watchdog expiry keeps the fresh frame.
        msg_d = msg_q;
        if (commit) begin
            msg_d = frame;
        end else if (expire) begin
            msg_d.ready = 1'b0;
            msg_d.hit   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_HDR;
            gap_q   <= '0;
            rh_q    <= 2'b00;
            msg_q   <= '0;
`ifdef LINK_CHECKSUM_EN
            cords_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rh_q    <= rh_d;
            msg_q   <= msg_d;
`ifdef LINK_CHECKSUM_EN
            cords_q <= cords_d;
`endif
        end
    end

    assign msg = msg_q;

endmodule

// File: rtl/link_ctrl.sv
// Link stage between main_fsm and the UART: frames the local triple for TX, instantiates the
// receiver and runs the link watchdog. LINK_CHECKSUM_EN adds a trailing XOR checksum byte.
module link_ctrl
    import link_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int RX_GAP_CYCLES  = 10_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready1,
    input  logic       hit1,
    input  logic [7:0] ship_cords_out,
    output logic       ready2,
    output logic       hit2,
    output logic [7:0] ship_cords_in,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       link_up
);

    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    tx_state_t        tx_state_q, tx_state_d;
    link_msg_t        live, snap_q, snap_d, last_sent_q, last_sent_d, rx_msg;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_wr_q, tx_wr_d;
    logic             link_up_q, link_up_d;
    logic             commit, expire;

    assign live = {ready1, hit1, ship_cords_out};

    link_rx #(
        .RX_GAP_CYCLES(RX_GAP_CYCLES)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .expire  (expire),
        .commit  (commit),
        .msg     (rx_msg)
    );

    always_comb begin
        tx_state_d  = tx_state_q;
        snap_d      = snap_q;
        last_sent_d = last_sent_q;
        refresh_d   = (refresh_q == REF_MAX) ? refresh_q : refresh_q + REF_W'(1);
        tx_data_d   = tx_data_q;
        tx_wr_d     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (live != last_sent_q || refresh_q >= REF_W'(REFRESH_CYCLES - 1)) begin
                    snap_d      = live;
                    last_sent_d = live;
                    refresh_d   = '0;
                    tx_state_d  = TX_HDR;
                end
            end
            TX_HDR: begin
                if (!tx_busy) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = hdr_byte(snap_q.ready, snap_q.hit);
                    tx_state_d = TX_CORDS;
                end
            end
            TX_CORDS: begin
                if (!tx_busy) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = snap_q.cords;
`ifdef LINK_CHECKSUM_EN
                    tx_state_d = TX_CHK;
`else
                    tx_state_d = TX_IDLE;
`endif
                end
            end
`ifdef LINK_CHECKSUM_EN
            TX_CHK: begin
                if (!tx_busy) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = hdr_byte(snap_q.ready, snap_q.hit) ^ snap_q.cords;
                    tx_state_d = TX_IDLE;
                end
            end
`endif
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Expiry fires on the edge where the silent-cycle count reaches TIMEOUT_CYCLES.
    always_comb begin
        expire    = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));
        wd_d      = commit ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1));
        link_up_d = commit ? 1'b1 : (expire ? 1'b0 : link_up_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            snap_q      <= '0;
            last_sent_q <= '0;
            refresh_q   <= '0;
            wd_q        <= '0;
            tx_data_q   <= 8'h00;
            tx_wr_q     <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            snap_q      <= snap_d;
            last_sent_q <= last_sent_d;
            refresh_q   <= refresh_d;
            wd_q        <= wd_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            link_up_q   <= link_up_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_wr         = tx_wr_q;
    assign link_up       = link_up_q;
    assign ready2        = rx_msg.ready;
    assign hit2          = rx_msg.hit;
    assign ship_cords_in = rx_msg.cords;

endmodule

// File: tb/tb_link_ctrl.sv
// Self-checking bench for link_ctrl: TX vector table, directed RX/timing corners, and randomized
// TX/RX traffic checked against a frame-level model. Honours LINK_CHECKSUM_EN for frame length.
module tb_link_ctrl;

    localparam int REFRESH = 64;
    localparam int TIMEOUT = 300;
    localparam int GAP     = 20;
`ifdef LINK_CHECKSUM_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 2;
`endif

    logic       clk, rst;
    logic       ready1, hit1;
    logic [7:0] ship_cords_out;
    logic       ready2, hit2;
    logic [7:0] ship_cords_in;
    logic [7:0] tx_data;
    logic       tx_wr, tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       link_up;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    link_ctrl #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RX_GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ready1        (ready1),
        .hit1          (hit1),
        .ship_cords_out(ship_cords_out),
        .ready2        (ready2),
        .hit2          (hit2),
        .ship_cords_in (ship_cords_in),
        .tx_data       (tx_data),
        .tx_wr         (tx_wr),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .link_up       (link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic       r;
        logic       h;
        logic [7:0] c;
        logic [7:0] exp_hdr;
        logic [7:0] exp_cords;
    } txv_t;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of a frame byte, straight from the wire format.
    function automatic logic [7:0] frame_byte(input logic r, input logic h, input logic [7:0] c,
                                              input int idx);
        logic [7:0] hdr;
        hdr = 8'hA0 + {6'd0, r, h};
        if (idx == 0) return hdr;
        if (idx == 1) return c;
        return hdr ^ c;
    endfunction

    task automatic set_triple(input logic r, input logic h, input logic [7:0] c);
        ready1 = r;
        hit1 = h;
        ship_cords_out = c;
    endtask

    task automatic collect_frame(input bit rand_busy, output logic [23:0] fb, output int lat0,
                                 output int lat_last, output bit ok);
        int got = 0;
        int t = 0;
        fb = '0;
        lat0 = -1;
        lat_last = -1;
        while (got < FLEN && t < 300) begin
            if (rand_busy) tx_busy = ($urandom_range(0, 3) == 0);
            tick();
            t++;
            if (tx_wr) begin
                fb[8*got +: 8] = tx_data;
                if (got == 0) lat0 = t;
                lat_last = t;
                got++;
            end
        end
        tx_busy = 1'b0;
        ok = (got == FLEN);
    endtask

    task automatic check_frame(input string name, input logic [23:0] fb, input bit ok,
                               input logic r, input logic h, input logic [7:0] c);
        chk({name, "_complete"}, 32'(ok), 32'd1);
        for (int i = 0; i < FLEN; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(fb[8*i +: 8]), 32'(frame_byte(r, h, c, i)));
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic r, input logic h, input logic [7:0] c,
                              input bit good_chk, input int gap_max);
        logic [7:0] chkb;
        chkb = frame_byte(r, h, c, 2);
        rx_byte(frame_byte(r, h, c, 0));
        idle($urandom_range(0, gap_max));
        rx_byte(c);
`ifdef LINK_CHECKSUM_EN
        idle($urandom_range(0, gap_max));
        if (!good_chk) chkb = chkb ^ (8'd1 << $urandom_range(0, 7));
        rx_byte(chkb);
`else
        if (!good_chk) chkb = 8'h00;
`endif
    endtask

    logic [23:0] fb;
    int          lat0, lat_last, cnt;
    bit          ok;
    txv_t        tv[5];
    logic        cr, ch, mr, mh, ever, up;
    logic [7:0]  cc, mc, jb;
    int          last_commit, kind;

    initial begin
        tv[0] = '{1'b1, 1'b1, 8'h35, 8'hA3, 8'h35};
        tv[1] = '{1'b0, 1'b1, 8'hFF, 8'hA1, 8'hFF};
        tv[2] = '{1'b1, 1'b0, 8'h00, 8'hA2, 8'h00};
        tv[3] = '{1'b0, 1'b0, 8'h5A, 8'hA0, 8'h5A};
        tv[4] = '{1'b1, 1'b1, 8'hA3, 8'hA3, 8'hA3};

        rst = 1'b1;
        set_triple(1'b0, 1'b0, 8'h00);
        tx_busy = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        chk("reset_ready2", 32'(ready2), 32'd0);
        chk("reset_hit2", 32'(hit2), 32'd0);
        chk("reset_cords_in", 32'(ship_cords_in), 32'h00);
        chk("reset_tx_data", 32'(tx_data), 32'h00);
        chk("reset_tx_wr", 32'(tx_wr), 32'd0);
        chk("reset_link_up", 32'(link_up), 32'd0);
        rst = 1'b0;

        // Unchanged inputs: only the refresh timer can start a frame.
        collect_frame(1'b0, fb, lat0, lat_last, ok);
        chk("refresh_not_early", 32'(lat0 >= REFRESH), 32'd1);
        chk("refresh_not_late", 32'(lat0 <= REFRESH + 2), 32'd1);
        check_frame("refresh", fb, ok, 1'b0, 1'b0, 8'h00);
        $display("tx refresh frame hdr=%02h cords=%02h at cycle %0d", fb[7:0], fb[15:8], lat0);

        for (int i = 0; i < 5; i++) begin
            set_triple(tv[i].r, tv[i].h, tv[i].c);
            collect_frame(1'b0, fb, lat0, lat_last, ok);
            chk($sformatf("vec%0d_hdr", i), 32'(fb[7:0]), 32'(tv[i].exp_hdr));
            chk($sformatf("vec%0d_cords", i), 32'(fb[15:8]), 32'(tv[i].exp_cords));
`ifdef LINK_CHECKSUM_EN
            chk($sformatf("vec%0d_chk", i), 32'(fb[23:16]), 32'(tv[i].exp_hdr ^ tv[i].exp_cords));
`endif
            chk($sformatf("vec%0d_latency", i), 32'(lat0), 32'd2);
            chk($sformatf("vec%0d_back_to_back", i), 32'(lat_last - lat0), 32'(FLEN - 1));
            $display("tx vec %0d hdr=%02h cords=%02h latency=%0d", i, fb[7:0], fb[15:8], lat0);
        end

        // tx_busy stall between header and cords, with a mid-frame input change.
        set_triple(1'b1, 1'b1, 8'h35);
        idle(2);
        chk("busy_hdr_wr", 32'(tx_wr), 32'd1);
        chk("busy_hdr_data", 32'(tx_data), 32'hA3);
        tx_busy = 1'b1;
        ship_cords_out = 8'h36;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_wr) cnt++;
        end
        chk("busy_no_wr", 32'(cnt), 32'd0);
        chk("busy_data_held", 32'(tx_data), 32'hA3);
        tx_busy = 1'b0;
        tick();
        chk("busy_cords_wr", 32'(tx_wr), 32'd1);
        chk("busy_cords_data", 32'(tx_data), 32'h35);
`ifdef LINK_CHECKSUM_EN
        tick();
        chk("busy_chk_data", 32'(tx_data), 32'(8'hA3 ^ 8'h35));
`endif
        collect_frame(1'b0, fb, lat0, lat_last, ok);
        check_frame("busy_followup", fb, ok, 1'b1, 1'b1, 8'h36);
        $display("tx follow-up frame hdr=%02h cords=%02h", fb[7:0], fb[15:8]);

        // Randomized TX traffic with a jittering tx_busy.
        cr = 1'b1; ch = 1'b1; cc = 8'h36;
        for (int i = 0; i < 20; i++) begin
            logic nr, nh;
            logic [7:0] nc;
            do begin
                nr = 1'($urandom_range(0, 1));
                nh = 1'($urandom_range(0, 1));
                nc = 8'($urandom_range(0, 255));
            end while (nr == cr && nh == ch && nc == cc);
            cr = nr; ch = nh; cc = nc;
            set_triple(cr, ch, cc);
            collect_frame(1'b1, fb, lat0, lat_last, ok);
            check_frame($sformatf("rand_tx%0d", i), fb, ok, cr, ch, cc);
            $display("tx rand %0d hdr=%02h cords=%02h", i, fb[7:0], fb[15:8]);
        end

        // Reset in the middle of a TX frame and of an RX frame.
        set_triple(1'b0, 1'b1, 8'h77);
        tick();
        rx_data = 8'hA2;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("midrst_hdr_wr", 32'(tx_wr), 32'd1);
        set_triple(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_wr", 32'(tx_wr), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'h00);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_wr) cnt++;
        end
        chk("midrst_no_more_wr", 32'(cnt), 32'd0);
        rx_byte(8'h15);
        chk("midrst_rx_ready2", 32'(ready2), 32'd0);
        chk("midrst_rx_cords", 32'(ship_cords_in), 32'h00);

        // Junk byte, then a header whose cords byte looks like a header.
        rx_byte(8'h7F);
        chk("rx_junk_ready2", 32'(ready2), 32'd0);
        rx_byte(8'hA2);
        chk("rx_hdr_no_commit", 32'(link_up), 32'd0);
        rx_byte(8'hA3);
`ifdef LINK_CHECKSUM_EN
        rx_byte(8'hA2 ^ 8'hA3);
`endif
        chk("rx_ready2", 32'(ready2), 32'd1);
        chk("rx_hit2", 32'(hit2), 32'd0);
        chk("rx_cords", 32'(ship_cords_in), 32'hA3);
        chk("rx_link_up", 32'(link_up), 32'd1);
        $display("rx frame ready2=%0b hit2=%0b cords=%02h", ready2, hit2, ship_cords_in);

        // Gap of RX_GAP_CYCLES drops the partial frame; one cycle less does not.
        rx_byte(8'hA1);
        idle(GAP);
        rx_byte(8'h44);
        chk("gap_drop_ready2", 32'(ready2), 32'd1);
        chk("gap_drop_hit2", 32'(hit2), 32'd0);
        chk("gap_drop_cords", 32'(ship_cords_in), 32'hA3);
        rx_byte(8'hA1);
        idle(GAP - 1);
        rx_byte(8'h5C);
`ifdef LINK_CHECKSUM_EN
        rx_byte(8'hA1 ^ 8'h5C);
`endif
        chk("gap_edge_ready2", 32'(ready2), 32'd0);
        chk("gap_edge_hit2", 32'(hit2), 32'd1);
        chk("gap_edge_cords", 32'(ship_cords_in), 32'h5C);

        // Watchdog: link stays up for TIMEOUT cycles after the commit, then drops.
        idle(TIMEOUT - 1);
        chk("wd_still_up", 32'(link_up), 32'd1);
        chk("wd_still_hit", 32'(hit2), 32'd1);
        tick();
        chk("wd_link_down", 32'(link_up), 32'd0);
        chk("wd_ready2", 32'(ready2), 32'd0);
        chk("wd_hit2", 32'(hit2), 32'd0);
        chk("wd_cords_held", 32'(ship_cords_in), 32'h5C);

`ifdef LINK_CHECKSUM_EN
        rx_byte(8'hA3); rx_byte(8'h12); rx_byte(8'hB1);
        chk("cs_good_ready2", 32'(ready2), 32'd1);
        chk("cs_good_cords", 32'(ship_cords_in), 32'h12);
        chk("cs_good_link", 32'(link_up), 32'd1);
        rx_byte(8'hA3); rx_byte(8'h12); rx_byte(8'hB0);
        rx_byte(8'hA0); rx_byte(8'h77); rx_byte(8'hD6);
        chk("cs_bad_ready2", 32'(ready2), 32'd1);
        chk("cs_bad_hit2", 32'(hit2), 32'd1);
        chk("cs_bad_cords", 32'(ship_cords_in), 32'h12);
`endif

        // Randomized RX stream checked against a frame-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mr = 1'b0; mh = 1'b0; mc = 8'h00; ever = 1'b0; last_commit = cyc;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                do jb = 8'($urandom_range(0, 255)); while (jb[7:2] == 6'b101000);
                rx_byte(jb);
                idle($urandom_range(0, 3));
            end else if (kind == 8) begin
                rx_byte(frame_byte(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00, 0));
                idle(GAP + 2);
`ifdef LINK_CHECKSUM_EN
            end else if (kind == 9) begin
                send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 255)), 1'b0, GAP - 2);
`endif
            end else begin
                mr = 1'($urandom_range(0, 1));
                mh = 1'($urandom_range(0, 1));
                mc = 8'($urandom_range(0, 255));
                send_frame(mr, mh, mc, 1'b1, GAP - 2);
                ever = 1'b1;
                last_commit = cyc;
                if (($urandom_range(0, 7)) == 0) idle(TIMEOUT);
            end
            up = ever && ((cyc - last_commit) < TIMEOUT);
            chk($sformatf("rand_rx%0d_link_up", i), 32'(link_up), 32'(up));
            chk($sformatf("rand_rx%0d_ready2", i), 32'(ready2), 32'(up & mr));
            chk($sformatf("rand_rx%0d_hit2", i), 32'(hit2), 32'(up & mh));
            chk($sformatf("rand_rx%0d_cords", i), 32'(ship_cords_in), 32'(mc));
            $display("rx rand %0d kind=%0d ready2=%0b hit2=%0b cords=%02h link_up=%0b",
                     i, kind, ready2, hit2, ship_cords_in, link_up);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
